// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
//   fw_sel_e  : legacy 2-bit bypass select encoding (FW_DEPTH = 2)
//   LAT_*     : canonical producer latencies
//   clamp_lat : maps a raw producer latency into [1, max_lat]
package fwd_scoreboard_pkg;

   typedef enum logic [1:0] {
      FW_NONE    = 2'd0,
      FW_MEM_ALU = 2'd1,
      FW_WB_DATA = 2'd2
   } fw_sel_e;

   localparam int unsigned LAT_ALU  = 1;
   localparam int unsigned LAT_LOAD = 2;

   // A zero latency is treated as a single-cycle op; anything above max_lat saturates.
   function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
      if (lat == 0) begin
         return 1;
      end
      if (lat > max_lat) begin
         return max_lat;
      end
      return lat;
   endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Pending-write countdown for one architectural register.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : accepted issue targets this register this edge
//   load_val_i  : countdown value loaded on load_i
//   cnt_o       : current countdown
//   busy_o      : countdown is nonzero
module sb_reg_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load takes priority over the saturating decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// ID-stage forwarding scoreboard: per-register latency countdowns drive bypass
// selection, load-use / multi-cycle stalls and WAW ordering stalls.
//   clk, rst          : clock, asynchronous active-high reset
//   src_addr_i/used_i : source operands of the instruction in ID
//   issue_*           : instruction leaving ID at this edge and its write info
//   flush_i           : cancels this cycle's issue
//   fw_sel_o          : per operand, 0 = register file, k+1 = bypass stage k
//   stall_o           : hold ID and insert a bubble
//   busy_o            : per-register pending-write flag
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter  int unsigned NUM_REGS = 32,
   parameter  int unsigned NUM_SRC  = 2,
   parameter  int unsigned FW_DEPTH = 2,
   parameter  int unsigned MAX_LAT  = 4,
   localparam int unsigned RA_W     = $clog2(NUM_REGS),
   localparam int unsigned LAT_W    = $clog2(MAX_LAT + 1),
   localparam int unsigned SEL_W    = $clog2(FW_DEPTH + 1),
   localparam int unsigned CNT_W    = $clog2(MAX_LAT + FW_DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC-1:0][RA_W-1:0]    src_addr_i,
   input  logic [NUM_SRC-1:0]              src_used_i,
   input  logic                            issue_valid_i,
   input  logic                            issue_regwrite_i,
   input  logic [RA_W-1:0]                 issue_rd_i,
   input  logic [LAT_W-1:0]                issue_lat_i,
   input  logic                            flush_i,
   output logic [NUM_SRC-1:0][SEL_W-1:0]   fw_sel_o,
   output logic                            stall_o,
   output logic [NUM_REGS-1:0]             busy_o
);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [NUM_SRC-1:0][CNT_W-1:0]  src_cnt;
   logic [LAT_W-1:0]               lat_eff;
   logic [CNT_W-1:0]               load_val;
   logic                           op_stall;
   logic                           waw;
   logic                           accept;

   // Countdown loaded on issue: result exists after lat_eff cycles, then stays
   // visible for FW_DEPTH-1 more cycles across the bypass stages.
   always_comb begin
      lat_eff  = LAT_W'(clamp_lat(32'(issue_lat_i), MAX_LAT));
      load_val = CNT_W'(32'(lat_eff) + FW_DEPTH - 1);
   end

   // Operand query: countdown v within [1, FW_DEPTH] maps to bypass FW_DEPTH-v,
   // larger means the result is not produced yet.
   always_comb begin
      fw_sel_o = '0;
      src_cnt  = '0;
      op_stall = 1'b0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         fw_sel_o[s] = SEL_W'(FW_NONE);
         src_cnt[s]  = cnt[src_addr_i[s]];
         if (src_used_i[s] && (src_addr_i[s] != '0) && (src_cnt[s] != '0)) begin
            if (32'(src_cnt[s]) <= FW_DEPTH) begin
               fw_sel_o[s] = SEL_W'(FW_DEPTH + 1 - 32'(src_cnt[s]));
            end else begin
               op_stall = 1'b1;
            end
         end
      end
   end

   // A new write may not finish before an older in-flight write to the same rd.
   always_comb begin
      waw     = issue_regwrite_i && (cnt[issue_rd_i] > load_val);
      stall_o = op_stall || (issue_valid_i && waw);
      accept  = issue_valid_i && issue_regwrite_i && !stall_o && !flush_i
                && (issue_rd_i != '0);
   end

   assign cnt[0]    = '0;
   assign busy_o[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      sb_reg_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk        (clk),
         .rst        (rst),
         .load_i     (accept && (issue_rd_i == RA_W'(r))),
         .load_val_i (load_val),
         .cnt_o      (cnt[r]),
         .busy_o     (busy_o[r])
      );
   end

endmodule
